// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, NZCV flag bit positions and
// the carry-in selection used by the add/subtract datapath.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_ADC = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_SBC = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // SUB is a + ~b + 1; ADC/SBC take the incoming carry flag.
  function automatic logic carry_in(input logic [1:0] op, input logic cin);
    case (op)
      ALU_ADD: return 1'b0;
      ALU_SUB: return 1'b1;
      ALU_ADC, ALU_SBC: return cin;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Single-level carry-lookahead adder: every carry is a sum-of-products of the
// generate/propagate terms below it and the carry-in.
module carry_lookahead_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             acc;
  logic             pp;

  assign g = A & B;
  assign p = A ^ B;

  always_comb begin
    acc = 1'b0;
    pp  = 1'b0;
    c   = '0;
    c[0] = Cin;
    for (int i = 0; i < WIDTH; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & Cin);
    end
  end

  assign S    = p ^ c[WIDTH-1:0];
  assign Cout = c[WIDTH];

endmodule

// File: rtl/pipelined_cla_alu_adder.sv
// Pipelined ADD/ADC/SUB/SBC with NZCV flags: one CLA chunk per stage, carry and
// running zero registered between stages, whole pipeline stalls on backpressure.
module pipelined_cla_alu_adder
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       flags
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (WIDTH % STAGES != 0) begin : g_bad_split
    $error("pipelined_cla_alu_adder: WIDTH must be a multiple of STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             c_q   [STAGES];
  logic             z_q   [STAGES];

  assign en       = !vld_q[LAST] || out_ready;
  assign in_ready = en;
  assign b_in     = op[1] ? ~b : b;
  assign c_in     = carry_in(op, cin);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             vld_src;
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] sum_src;
    logic             c_src;
    logic             z_src;
    logic [CW-1:0]    chunk;
    logic             co;
    logic [WIDTH-1:0] sum_nxt;

    logic             vld_p;
    logic [WIDTH-1:0] a_p;
    logic [WIDTH-1:0] b_p;
    logic [WIDTH-1:0] sum_p;
    logic             c_p;
    logic             z_p;

    if (k == 0) begin : g_first
      assign vld_src = in_valid;
      assign a_src   = a;
      assign b_src   = b_in;
      assign sum_src = '0;
      assign c_src   = c_in;
      assign z_src   = 1'b1;
    end else begin : g_next
      assign vld_src = vld_q[k-1];
      assign a_src   = a_q[k-1];
      assign b_src   = b_q[k-1];
      assign sum_src = sum_q[k-1];
      assign c_src   = c_q[k-1];
      assign z_src   = z_q[k-1];
    end

    carry_lookahead_adder #(.WIDTH(CW)) u_cla (
      .A   (a_src[k*CW +: CW]),
      .B   (b_src[k*CW +: CW]),
      .Cin (c_src),
      .S   (chunk),
      .Cout(co)
    );

    always_comb begin
      sum_nxt = sum_src;
      sum_nxt[k*CW +: CW] = chunk;
    end

    // Stage k register boundary: operands ride along skewed, finished chunks accumulate.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_p <= 1'b0;
        a_p   <= '0;
        b_p   <= '0;
        sum_p <= '0;
        c_p   <= 1'b0;
        z_p   <= 1'b0;
      end else if (en) begin
        vld_p <= vld_src;
        a_p   <= a_src;
        b_p   <= b_src;
        sum_p <= sum_nxt;
        c_p   <= co;
        z_p   <= z_src && (chunk == '0);
      end
    end

    assign vld_q[k] = vld_p;
    assign a_q[k]   = a_p;
    assign b_q[k]   = b_p;
    assign sum_q[k] = sum_p;
    assign c_q[k]   = c_p;
    assign z_q[k]   = z_p;
  end

  assign out_valid = vld_q[LAST];

  always_comb begin
    sum   = '0;
    flags = '0;
    if (vld_q[LAST]) begin
      sum           = sum_q[LAST];
      flags[FLAG_N] = sum_q[LAST][WIDTH-1];
      flags[FLAG_Z] = z_q[LAST];
      flags[FLAG_C] = c_q[LAST];
      flags[FLAG_V] = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                      (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
    end
  end

endmodule

// File: tb/tb_pipelined_cla_alu_adder.sv
// Scoreboard bench: three instances (STAGES 4, 1, 8) driven in lockstep; each
// has its own expected-result queue checked by an independent output monitor.
module tb_pipelined_cla_alu_adder;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         vin, orv, cin;
  logic [W-1:0] a, b;
  logic [1:0]   op;
  logic         rdy [NI];
  logic         ov  [NI];
  logic [W-1:0] sm  [NI];
  logic [3:0]   fl  [NI];
  int           qsz [NI];
  logic         rdy_all, iv;

  assign rdy_all = rdy[0] && rdy[1] && rdy[2];
  assign iv      = vin && rdy_all;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit           lat_mode, use_tab, done;
  logic [W-1:0] tab_sum;
  logic [3:0]   tab_fl;

  typedef struct {
    logic [W-1:0] s;
    logic [3:0]   f;
    int           acc;
    bit           lat;
  } exp_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, overflow judged on the true signed sum.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [1:0] mop, input logic mcin);
    exp_t         e;
    logic [W-1:0] bp;
    logic         c0;
    logic [63:0]  full;
    longint       sv;
    bp   = (mop == ALU_SUB || mop == ALU_SBC) ? ~mb : mb;
    c0   = (mop == ALU_ADD) ? 1'b0 : (mop == ALU_SUB) ? 1'b1 : mcin;
    full = 64'(ma) + 64'(bp) + 64'(c0);
    sv   = longint'($signed(ma)) + longint'($signed(bp)) + longint'(c0);
    e.s  = full[W-1:0];
    e.f  = {full[W-1], (full[W-1:0] == '0), full[W],
            (sv > 64'sd2147483647) || (sv < -64'sd2147483648)};
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int ST = (g == 0) ? 4 : ((g == 1) ? 1 : 8);

    pipelined_cla_alu_adder #(.WIDTH(W), .STAGES(ST)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (iv),
      .in_ready (rdy[g]),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .op       (op),
      .out_valid(ov[g]),
      .out_ready(orv),
      .sum      (sm[g]),
      .flags    (fl[g])
    );

    exp_t         q[$];
    bit           hold = 1'b0;
    logic [W-1:0] hs;
    logic [3:0]   hf;

    always @(negedge clk) begin
      exp_t e;
      if (reset) begin
        q.delete();
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk($sformatf("hold_valid_s%0d", ST), 64'(ov[g]), 64'(1));
          chk($sformatf("hold_sum_s%0d", ST), 64'(sm[g]), 64'(hs));
          chk($sformatf("hold_flags_s%0d", ST), 64'(fl[g]), 64'(hf));
        end
        if (iv && rdy[g]) begin
          if (use_tab) begin
            e.s = tab_sum;
            e.f = tab_fl;
          end else begin
            e = model(a, b, op, cin);
          end
          e.acc = cyc + 1;
          e.lat = lat_mode;
          q.push_back(e);
        end
        if (ov[g] && orv) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_s%0d: output sum %0h flags %0h, expected none", ST, sm[g], fl[g]);
          end else begin
            e = q.pop_front();
            chk($sformatf("sum_s%0d", ST), 64'(sm[g]), 64'(e.s));
            chk($sformatf("flags_s%0d", ST), 64'(fl[g]), 64'(e.f));
            if (e.lat) chk($sformatf("latency_s%0d", ST), 64'(cyc - e.acc), 64'(ST - 1));
          end
        end
        hold = ov[g] && !orv;
        hs   = sm[g];
        hf   = fl[g];
      end
      qsz[g] = q.size();
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [1:0] top,
                      input logic tc, input logic [W-1:0] es, input logic [3:0] ef);
    bit acc;
    int n;
    a = ta; b = tb_v; op = top; cin = tc;
    tab_sum = es; tab_fl = ef;
    vin = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc) begin
      @(negedge clk);
      acc = rdy_all;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 300) begin
        $display("FAIL send_timeout: in_ready low for %0d cycles, expected acceptance", n);
        $fatal(1, "input handshake stuck");
      end
    end
    vin = 1'b0;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] s;
    logic [3:0]   f;
  } vec_t;

  vec_t dir[8] = '{
    '{ALU_ADD, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000},
    '{ALU_ADC, 32'h00000001, 32'hFFFFFFFF, 1'b1, 32'h00000001, 4'b0010},
    '{ALU_ADD, 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000000, 4'b0110},
    '{ALU_SUB, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 4'b0110},
    '{ALU_SUB, 32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 4'b1000},
    '{ALU_SBC, 32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFD, 4'b1000},
    '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b1001},
    '{ALU_SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 4'b0011}
  };

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'hFFFFFFFF;
      1: return 32'h80000000;
      2: return 32'h7FFFFFFF;
      3: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; vin = 1'b0; orv = 1'b1;
    a = '0; b = '0; cin = 1'b0; op = ALU_ADD;
    lat_mode = 1'b0; use_tab = 1'b0; done = 1'b0;
    tab_sum = '0; tab_fl = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_valid_%0d", i), 64'(ov[i]), 64'(0));
      chk($sformatf("rst_sum_%0d", i), 64'(sm[i]), 64'(0));
      chk($sformatf("rst_flags_%0d", i), 64'(fl[i]), 64'(0));
      chk($sformatf("rst_in_ready_%0d", i), 64'(rdy[i]), 64'(1));
    end
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed vectors, one at a time, latency checked.
    lat_mode = 1'b1;
    use_tab  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(dir[i].a, dir[i].b, dir[i].op, dir[i].cin, dir[i].s, dir[i].f);
      repeat (12) @(posedge clk);
      #1;
    end
    use_tab  = 1'b0;
    lat_mode = 1'b0;

    // Back-to-back stream with a 3-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 8; i++) send(W'(i), 32'd100, ALU_ADD, 1'b0, '0, '0);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!ov[0] && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("stream_first_valid", 64'(ov[0]), 64'(1));
        @(posedge clk);
        #1 orv = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_out_valid", 64'(ov[0]), 64'(1));
          for (int i = 0; i < NI; i++)
            chk($sformatf("stall_in_ready_%0d", i), 64'(rdy[i]), 64'(!ov[i]));
          @(posedge clk);
          #1;
        end
        orv = 1'b1;
      end
    join
    repeat (15) @(posedge clk);
    #1;

    // Random operations with random backpressure.
    done = 1'b0;
    fork
      begin
        repeat (80) begin
          send(pick(), pick(), 2'($urandom), 1'($urandom), '0, '0);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          orv = ($urandom % 4) != 0;
          @(posedge clk);
          #1;
        end
        orv = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk($sformatf("drained_%0d", i), 64'(qsz[i]), 64'(0));

    // Asynchronous reset with operations in flight.
    @(posedge clk);
    #1;
    orv = 1'b1;
    send(32'd10, 32'd20, ALU_ADD, 1'b0, '0, '0);
    send(32'd30, 32'd5, ALU_SUB, 1'b0, '0, '0);
    send(32'hFFFFFFFF, 32'd1, ALU_ADD, 1'b0, '0, '0);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("async_rst_valid_%0d", i), 64'(ov[i]), 64'(0));
      chk($sformatf("async_rst_sum_%0d", i), 64'(sm[i]), 64'(0));
      chk($sformatf("async_rst_flags_%0d", i), 64'(fl[i]), 64'(0));
      chk($sformatf("async_rst_in_ready_%0d", i), 64'(rdy[i]), 64'(1));
    end
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++)
        chk($sformatf("post_rst_idle_%0d", i), 64'(ov[i]), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_alu_adder.md
Name: pipelined_cla_alu_adder

Overview:
Parametrised, pipelined adder/subtractor for the ARM datapath, built from the carry_lookahead_adder building block. WIDTH is split into STAGES equal chunks, with one CLA chunk per pipeline stage; the carry is registered between stages. Supports ADD/ADC/SUB/SBC and produces ARM NZCV flags. Valid/ready handshake on both sides with full-pipeline stall. Accepts one operation per cycle.

Parameters:
WIDTH, 32, operand/result width in bits.
STAGES, 4, number of pipeline stages; must divide WIDTH (chunk width CW = WIDTH/STAGES); STAGES=1 is legal.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high; clears all pipeline state.
in_valid  input  1  operands/op valid this cycle.
in_ready  output  1  block can accept; transfer when in_valid && in_ready.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry flag input, used by ADC/SBC only.
op  input  2  00 ADD, 01 ADC, 10 SUB, 11 SBC.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
sum  output  WIDTH  result.
flags  output  4  {N,Z,C,V}.

Behaviour:
- Operand prep at input: b' = op[1] ? ~b : b. Carry-in c0 = ADD:0, ADC:cin, SUB:1, SBC:cin.
- Stage k (0..STAGES-1) adds chunk k (bits k*CW +: CW) of a and b' plus the registered carry from stage k-1 (c0 for stage 0).
- Unconsumed upper operand chunks travel skewed through the stage registers. Completed lower sum chunks are carried forward.
- Running zero flag: Z_k = Z_{k-1} && (chunk sum == 0), carried per stage.
- Final stage outputs:
  - N = sum[WIDTH-1]
  - Z = accumulated zero
  - C = carry out of MSB
  - V = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB])
  - a[MSB] and b'[MSB] are carried to the last stage.
- Latency: a result accepted at edge t is presented with out_valid=1 after edge t+STAGES-1 (i.e. visible the cycle after STAGES rising edges, counting the accept edge). Throughput: 1 per cycle.
- Stall: global advance enable en = !out_valid || out_ready. in_ready = en (combinational). When en=0, every stage register holds, including valid bits. Bubbles are not compressed.
- Each stage has a valid bit; data registers load only when en=1. Invalid stages may hold arbitrary data but outputs are gated: sum=0 and flags=0 when out_valid=0.
- out_valid, sum and flags are stable while out_valid && !out_ready.
- Reset (any time, including mid-operation): all valid bits, data regs, sum and flags go to 0 immediately. in_ready=1 while out_ready is don't-care. In-flight operations are discarded; none reappear after release.
- Wrap-around: the sum is modulo 2^WIDTH; the carry is reported only via C.
- Simultaneous accept and emit in the same cycle with out_ready=1: both happen and no slot is lost.

Decomposition:
- Shared package alu_pkg:
  - op encodings ALU_ADD=2'b00, ALU_ADC=2'b01, ALU_SUB=2'b10, ALU_SBC=2'b11.
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module: the existing carry_lookahead_adder #(CW), instantiated once per stage in a generate loop (ports A, B, Cin, S, Cout). Pipeline registers and flag logic live in this block.
- Elaboration check: fail if WIDTH % STAGES != 0.

Test Plan:
- WIDTH=32, STAGES=4. ADD 1+1, out_ready=1 -> sum=2, flags=0000, out_valid high on the 4th cycle after accept, for exactly 1 cycle.
- ADC a=1, b=0xFFFFFFFF, cin=1 -> sum=0x00000001, flags=0010 (C). ADD a=1, b=0xFFFFFFFF -> sum=0, flags=0110 (carry ripples through all 4 stages).
- SUB 5-5 -> sum=0, flags=0110. SUB 3-5 -> sum=0xFFFFFFFE, flags=1000. SBC 3-5 with cin=0 -> sum=0xFFFFFFFD, flags=1000.
- ADD 0x7FFFFFFF+1 -> sum=0x80000000, flags=1001. SUB 0x80000000-1 -> sum=0x7FFFFFFF, flags=0011.
- Stream 8 back-to-back ADDs (a=i, b=100). Drop out_ready for 3 cycles while results are emerging -> in_ready low for the same 3 cycles. Outputs are 100..107 in order with no loss or duplication, and the held output stays stable. Repeat with STAGES=1 and STAGES=8.
- Load 3 ops, assert reset asynchronously mid-cycle -> out_valid, sum and flags go to 0 before the next edge. After release with in_valid=0 for 10 cycles, out_valid stays 0.
